// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between two pipeline stages wrapped around pipe_stage_skid.
// The stage itself takes the slave view; the surrounding logic takes the master view.
interface pipe_stage_skid_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;

   modport master (
      output flush, in_valid, in_data, in_ctrl, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl
   );

   modport slave (
      input  flush, in_valid, in_data, in_ctrl, out_ready,
      output in_ready, out_valid, out_data, out_ctrl
   );
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a 2-entry skid buffer, flush and bubble gating.
// Optional saturating back-pressure counter enabled by the PIPE_STALL_CNT_EN macro.

// Invariant monitor for the stage outputs, sampled away from the active edge.
module pipe_stage_skid_chk #(
   parameter int CTRL_W = 8
) (
   input logic              clk,
   input logic              rst,
   input logic              in_ready,
   input logic              out_valid,
   input logic [CTRL_W-1:0] out_ctrl
);
   // A bubble never carries control, and a blocked input implies a held head beat.
   always @(negedge clk) begin
      if (rst) begin
         assert (out_valid || (out_ctrl == {CTRL_W{1'b0}}));
         assert (out_valid || in_ready);
      end
   end
endmodule

module pipe_stage_skid #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
`ifdef PIPE_STALL_CNT_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   pipe_stage_skid_if.slave  bus
`ifdef PIPE_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [DATA_W-1:0] main_data_r;
   logic [DATA_W-1:0] main_data_s;
   logic [CTRL_W-1:0] main_ctrl_r;
   logic [CTRL_W-1:0] main_ctrl_s;
   logic [DATA_W-1:0] skid_data_r;
   logic [DATA_W-1:0] skid_data_s;
   logic [CTRL_W-1:0] skid_ctrl_r;
   logic [CTRL_W-1:0] skid_ctrl_s;
   logic              in_ready_r;
   logic              in_ready_s;
   logic              out_valid_r;
   logic              out_valid_s;
   logic              acc_s;
   logic              dlv_s;

   assign acc_s = bus.in_valid & in_ready_r;
   assign dlv_s = out_valid_r & bus.out_ready;

   // Next-state and storage update; main_ctrl is zeroed whenever the stage goes empty.
   always_comb begin
      state_s     = state_r;
      main_data_s = main_data_r;
      main_ctrl_s = main_ctrl_r;
      skid_data_s = skid_data_r;
      skid_ctrl_s = skid_ctrl_r;
      if (bus.flush) begin
         state_s     = EMPTY;
         main_ctrl_s = {CTRL_W{1'b0}};
         skid_ctrl_s = {CTRL_W{1'b0}};
      end else begin
         case (state_r)
            EMPTY: begin
               if (acc_s) begin
                  main_data_s = bus.in_data;
                  main_ctrl_s = bus.in_ctrl;
                  state_s     = FULL;
               end else begin
                  state_s     = EMPTY;
               end
            end
            FULL: begin
               if (acc_s && dlv_s) begin
                  main_data_s = bus.in_data;
                  main_ctrl_s = bus.in_ctrl;
                  state_s     = FULL;
               end else if (dlv_s) begin
                  main_ctrl_s = {CTRL_W{1'b0}};
                  state_s     = EMPTY;
               end else if (acc_s) begin
                  skid_data_s = bus.in_data;
                  skid_ctrl_s = bus.in_ctrl;
                  state_s     = SKID;
               end else begin
                  state_s     = FULL;
               end
            end
            SKID: begin
               if (dlv_s) begin
                  main_data_s = skid_data_r;
                  main_ctrl_s = skid_ctrl_r;
                  skid_ctrl_s = {CTRL_W{1'b0}};
                  state_s     = FULL;
               end else begin
                  state_s     = SKID;
               end
            end
            default: begin
               main_ctrl_s = {CTRL_W{1'b0}};
               skid_ctrl_s = {CTRL_W{1'b0}};
               state_s     = EMPTY;
            end
         endcase
      end
      in_ready_s  = (state_s != SKID);
      out_valid_s = (state_s != EMPTY);
   end

   // State and payload registers; handshake outputs come straight from flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= EMPTY;
         main_data_r <= {DATA_W{1'b0}};
         main_ctrl_r <= {CTRL_W{1'b0}};
         skid_data_r <= {DATA_W{1'b0}};
         skid_ctrl_r <= {CTRL_W{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         main_data_r <= main_data_s;
         main_ctrl_r <= main_ctrl_s;
         skid_data_r <= skid_data_s;
         skid_ctrl_r <= skid_ctrl_s;
         in_ready_r  <= in_ready_s;
         out_valid_r <= out_valid_s;
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = main_data_r;
   assign bus.out_ctrl  = main_ctrl_r;

`ifdef PIPE_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_r;

   // Saturating count of cycles a held beat is refused downstream; flush leaves it alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (out_valid_r && !bus.out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall_cnt = stall_cnt_r;
`endif

   pipe_stage_skid_chk #(.CTRL_W(CTRL_W)) u_chk (
      .clk       (clk),
      .rst       (rst),
      .in_ready  (in_ready_r),
      .out_valid (out_valid_r),
      .out_ctrl  (main_ctrl_r)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed vector table, reset/flush sequences and
// randomized traffic against a 2-deep FIFO reference model.
`timescale 1ns/1ps
module tb_pipe_stage_skid;
   localparam int DATA_W = 32;
   localparam int CTRL_W = 8;
   localparam int CNT_W  = 4;
   localparam int N_VEC  = 18;
   localparam int N_RAND = 3000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

`ifdef PIPE_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt;
   pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .stall_cnt (stall_cnt)
   );
`else
   pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
`endif

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [CTRL_W-1:0] ctrl;
   } beat_t;

   typedef struct packed {
      logic              flush;
      logic              in_valid;
      logic [DATA_W-1:0] in_data;
      logic [CTRL_W-1:0] in_ctrl;
      logic              out_ready;
      logic              exp_valid;
      logic [DATA_W-1:0] exp_data;
      logic [CTRL_W-1:0] exp_ctrl;
      logic              exp_ready;
   } vec_t;

   vec_t  tbl [N_VEC];
   beat_t q[$];
   int    stall_m;
   int    n_vec;
   int    n_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle, advance the FIFO model across the edge, leave time at edge+1.
   task automatic cycle(input logic f, input logic iv, input logic [DATA_W-1:0] d,
                        input logic [CTRL_W-1:0] c, input logic ordy);
      logic acc;
      logic dlv;
      beat_t b;
      bus.flush     = f;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.in_ctrl   = c;
      bus.out_ready = ordy;
      acc = iv && (q.size() < 2);
      dlv = (q.size() > 0) && ordy;
      if ((q.size() > 0) && !ordy && (stall_m < (1 << CNT_W) - 1)) stall_m++;
      @(posedge clk);
      if (f) begin
         q.delete();
      end else begin
         if (dlv) b = q.pop_front();
         if (acc) begin
            b.data = d;
            b.ctrl = c;
            q.push_back(b);
         end
      end
      #1;
   endtask

   task automatic compare_model(input string tag);
      logic v;
      v = (q.size() > 0);
      check({tag, ".out_valid"}, {63'd0, bus.out_valid}, {63'd0, v});
      check({tag, ".in_ready"}, {63'd0, bus.in_ready}, {63'd0, (q.size() < 2)});
      check({tag, ".out_ctrl"}, {56'd0, bus.out_ctrl}, {56'd0, (v ? q[0].ctrl : 8'h00)});
      if (v) check({tag, ".out_data"}, {32'd0, bus.out_data}, {32'd0, q[0].data});
`ifdef PIPE_STALL_CNT_EN
      check({tag, ".stall_cnt"}, {60'd0, stall_cnt}, stall_m);
`endif
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      stall_m = 0;
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ctrl = '0; bus.out_ready = 1'b0;

      //          flush iv    in_data      ctrl   ordy | valid data         ctrl   ready
      tbl[0]  = '{1'b0, 1'b1, 32'h1,       8'h11, 1'b1,  1'b1, 32'h1,       8'h11, 1'b1};
      tbl[1]  = '{1'b0, 1'b1, 32'h2,       8'h22, 1'b1,  1'b1, 32'h2,       8'h22, 1'b1};
      tbl[2]  = '{1'b0, 1'b1, 32'h3,       8'h33, 1'b1,  1'b1, 32'h3,       8'h33, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 32'h0,       8'h00, 1'b1,  1'b0, 32'h0,       8'h00, 1'b1};
      tbl[4]  = '{1'b0, 1'b1, 32'hA,       8'hAA, 1'b0,  1'b1, 32'hA,       8'hAA, 1'b1};
      tbl[5]  = '{1'b0, 1'b1, 32'hB,       8'hBB, 1'b0,  1'b1, 32'hA,       8'hAA, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 32'hD,       8'hDD, 1'b0,  1'b1, 32'hA,       8'hAA, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 32'h0,       8'h00, 1'b1,  1'b1, 32'hB,       8'hBB, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 32'h0,       8'h00, 1'b1,  1'b0, 32'h0,       8'h00, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 32'h10,      8'h10, 1'b0,  1'b1, 32'h10,      8'h10, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 32'h11,      8'h11, 1'b0,  1'b1, 32'h10,      8'h10, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 32'hC,       8'hCC, 1'b0,  1'b0, 32'h0,       8'h00, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 32'h0,       8'h00, 1'b1,  1'b0, 32'h0,       8'h00, 1'b1};
      tbl[13] = '{1'b0, 1'b1, 32'h20,      8'hFF, 1'b1,  1'b1, 32'h20,      8'hFF, 1'b1};
      tbl[14] = '{1'b0, 1'b0, 32'h0,       8'h00, 1'b1,  1'b0, 32'h0,       8'h00, 1'b1};
      tbl[15] = '{1'b0, 1'b0, 32'h0,       8'h00, 1'b1,  1'b0, 32'h0,       8'h00, 1'b1};
      tbl[16] = '{1'b0, 1'b1, 32'h30,      8'h30, 1'b0,  1'b1, 32'h30,      8'h30, 1'b1};
      tbl[17] = '{1'b1, 1'b1, 32'hDEAD,    8'h31, 1'b1,  1'b0, 32'h0,       8'h00, 1'b1};

      // Reset values while rst is held low.
      repeat (3) @(posedge clk);
      #1;
      check("reset.out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("reset.in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("reset.out_data", {32'd0, bus.out_data}, 64'd0);
      check("reset.out_ctrl", {56'd0, bus.out_ctrl}, 64'd0);
`ifdef PIPE_STALL_CNT_EN
      check("reset.stall_cnt", {60'd0, stall_cnt}, 64'd0);
`endif
      #2 rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < N_VEC; i++) begin
         cycle(tbl[i].flush, tbl[i].in_valid, tbl[i].in_data, tbl[i].in_ctrl, tbl[i].out_ready);
         check($sformatf("vec%0d.out_valid", i), {63'd0, bus.out_valid}, {63'd0, tbl[i].exp_valid});
         check($sformatf("vec%0d.in_ready", i), {63'd0, bus.in_ready}, {63'd0, tbl[i].exp_ready});
         check($sformatf("vec%0d.out_ctrl", i), {56'd0, bus.out_ctrl}, {56'd0, tbl[i].exp_ctrl});
         if (tbl[i].exp_valid)
            check($sformatf("vec%0d.out_data", i), {32'd0, bus.out_data}, {32'd0, tbl[i].exp_data});
      end

      // Asynchronous reset while two beats are held.
      cycle(1'b0, 1'b1, 32'h40, 8'h40, 1'b0);
      cycle(1'b0, 1'b1, 32'h41, 8'h41, 1'b0);
      check("skid.in_ready", {63'd0, bus.in_ready}, 64'd0);
      #2 rst = 1'b0;
      #1;
      check("arst.out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("arst.in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("arst.out_ctrl", {56'd0, bus.out_ctrl}, 64'd0);
      check("arst.out_data", {32'd0, bus.out_data}, 64'd0);
      q.delete();
      stall_m = 0;
      @(posedge clk);
      #2 rst = 1'b1;
      cycle(1'b0, 1'b1, 32'h5, 8'h55, 1'b1);
      check("post_rst.out_valid", {63'd0, bus.out_valid}, 64'd1);
      check("post_rst.out_data", {32'd0, bus.out_data}, 64'h5);
      check("post_rst.out_ctrl", {56'd0, bus.out_ctrl}, 64'h55);
      cycle(1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
      check("post_rst.drain", {63'd0, bus.out_valid}, 64'd0);

      // Randomized traffic against the FIFO model.
      for (int i = 0; i < N_RAND; i++) begin
         cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7),
               $urandom, 8'($urandom), ($urandom_range(0, 9) < 6));
         compare_model("rand");
      end

`ifdef PIPE_STALL_CNT_EN
      // Saturation of the stall counter and its immunity to flush.
      cycle(1'b0, 1'b1, 32'h77, 8'h77, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
      check("stall.saturate", {60'd0, stall_cnt}, 64'd15);
      cycle(1'b1, 1'b0, 32'h0, 8'h00, 1'b0);
      check("stall.after_flush", {60'd0, stall_cnt}, 64'd15);
      compare_model("stall");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic parametrised pipeline stage register. Successor to the fixed-field inter-stage registers such as EX/MEM.
- Carries an opaque data payload plus a control bundle (memwrite/regwrite/wb_src style enables) between two pipeline stages.
- Uses valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops a beat and never creates a combinational ready path.
- Synchronous flush kills in-flight beats for branch/jump redirect. Control bits are forced to zero on bubbles, so a bubble can never write memory or the register file.

Parameters:
- DATA_W, 32: payload width (ALU result, store data, pcplus4, etc. packed by the instantiating stage).
- CTRL_W, 8: control bundle width; gated to zero whenever out_valid=0.
- CNT_W, 16: stall counter width; used only with PIPE_STALL_CNT_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- flush  in  1  synchronous kill of all held beats.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat; driven directly from a register.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload of the head beat.
- out_ctrl  out  CTRL_W  control of the head beat; all zeros when out_valid=0.
- stall_cnt  out  CNT_W  present only with PIPE_STALL_CNT_EN.

Behaviour:
- Clock and reset: single clock domain. Asynchronous active-low reset; assertion takes effect immediately, and deassertion is used synchronously by the stage.
- Reset values: state=EMPTY, out_valid=0, in_ready=1, out_data=0, out_ctrl=0, skid contents=0, stall_cnt=0.
- Storage: main register (drives out_*) and skid register.
- States:
  - EMPTY: main invalid.
  - FULL: main valid, skid empty.
  - SKID: both valid.
- in_ready is registered: in_ready=1 in EMPTY and FULL, 0 in SKID.
- Accept: acc = in_valid & in_ready. Deliver: dlv = out_valid & out_ready.
- Transitions (no flush):
  - EMPTY: acc -> main<=in, go FULL. Otherwise stay.
  - FULL: acc&dlv -> main<=in, stay FULL. dlv only -> EMPTY. acc only -> skid<=in, go SKID. Neither -> stay.
  - SKID: dlv -> main<=skid, go FULL. Otherwise stay; no input is accepted.
- Latency and throughput: minimum latency 1 cycle from acc to out_valid. Sustained throughput 1 beat/cycle while out_ready=1.
- Ordering: strict FIFO; the skid beat always follows the main beat.
- Flush:
  - Highest priority. Next state is EMPTY, out_valid<=0, in_ready<=1.
  - A beat accepted in the flush cycle is discarded.
  - A dlv in the flush cycle is still a valid transfer, since downstream sampled it.
- Bubble gating: out_ctrl = out_valid ? main_ctrl : 0. out_data holds its last value when invalid; data is don't-care for checking.
- Holding rule: out_data and out_ctrl must not change while out_valid=1 and out_ready=0.
- Reset mid-operation: all held beats are lost immediately and outputs return to reset values.
- No X propagation: the register contents are fully reset.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, CNT_W bits.
  - Increments each cycle with out_valid=1 & out_ready=0.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by rst, not by flush.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Streaming: reset release, in_valid=1 with data 0x1,0x2,0x3 on consecutive cycles, out_ready=1 -> out_data 0x1,0x2,0x3 one cycle later each; in_ready stays 1; no beat lost.
- Back-pressure: send 0xA then 0xB with out_ready=0 -> state SKID, in_ready=0 on the next cycle, out_data holds 0xA. Raise out_ready for 2 cycles -> 0xA then 0xB delivered, in_ready=1 again.
- Flush: hold two beats (SKID), assert flush 1 cycle with in_valid=1 data 0xC -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0xC never appears.
- Bubble gating: in_ctrl=0xFF, one beat followed by idle -> out_ctrl=0xFF for exactly one cycle, then 0x00 while out_valid=0.
- Async reset: assert rst=0 mid-cycle while in SKID -> out_valid=0 and in_ready=1 before the next clk edge; after release the first beat 0x5 passes normally.
- Stall counter (PIPE_STALL_CNT_EN, CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15; flush leaves it at 15.
